regfile_mp: RTL

Parametrised multi-read-port integer register file with a per-register pending-write scoreboard, for the pipelined RISC-V core. It sits between decode (read addresses, issue of destination registers) and writeback (single write port). It generalises the single-cycle register file with configurable width, depth and read-port count, asynchronous reset, optional write-to-read bypass, and hazard (busy) flags for stall logic. Register 0 is hardwired to zero. One register mirrors the external trigger input.

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_mp_if.sv | 35 +++
 rtl/regfile_scoreboard.sv | 51 +++++
 rtl/regfile_mp.sv | 90 +++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared defaults, types and helpers for the multi-port regfile.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

   localparam int XLEN     = 32;
   localparam int NREGS    = 32;
   localparam int TRIG_IDX = 31;
   localparam int AW       = $clog2(NREGS);

   typedef logic [AW-1:0]   reg_addr_t;
   typedef logic [XLEN-1:0] xlen_t;

   localparam reg_addr_t REG_ZERO = '0;

   // Architectural writes never land on x0 or on the trigger mirror.
   function automatic logic is_writable(input int unsigned addr, input int unsigned trig);
      return (addr != 0) && (addr != trig);
   endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_mp_if.sv
// ============================================================================
// Module   : regfile_mp_if
// Purpose  : Read / issue / writeback bundle between pipeline and regfile.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_mp_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NREAD = 2
);
   localparam int AW = $clog2(NREGS);

   logic [NREAD-1:0][AW-1:0]   rd_addr;
   logic [NREAD-1:0][XLEN-1:0] rd_data;
   logic [NREAD-1:0]           rd_busy;
   logic                       iss_valid;
   logic [AW-1:0]              iss_rd;
   logic                       wb_en;
   logic [AW-1:0]              wb_addr;
   logic [XLEN-1:0]            wb_data;

   modport master (
      output rd_addr, iss_valid, iss_rd, wb_en, wb_addr, wb_data,
      input  rd_data, rd_busy
   );

   modport slave (
      input  rd_addr, iss_valid, iss_rd, wb_en, wb_addr, wb_data,
      output rd_data, rd_busy
   );
endinterface

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Per-register pending-write bits with NREAD lookup ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
   parameter int NREGS    = 32,
   parameter int NREAD    = 2,
   parameter int TRIG_IDX = 31,
   parameter int AW       = $clog2(NREGS)
) (
   input  wire logic                      clk,
   input  wire logic                      rst_n,
   input  wire logic                      iss_valid,
   input  wire logic [AW-1:0]             iss_rd,
   input  wire logic                      wb_en,
   input  wire logic [AW-1:0]             wb_addr,
   input  wire logic [NREAD-1:0][AW-1:0]  lk_addr,
   output logic      [NREAD-1:0]          lk_busy
);
   import regfile_pkg::*;

   logic [NREGS-1:0] r_busy;
   logic             w_set;
   logic             w_clr;

   assign w_set = iss_valid && is_writable(int'(iss_rd),  TRIG_IDX);
   assign w_clr = wb_en     && is_writable(int'(wb_addr), TRIG_IDX);

   // Set is applied last so a same-cycle (younger) issue keeps the bit busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         if (w_clr) r_busy[wb_addr] <= 1'b0;
         if (w_set) r_busy[iss_rd]  <= 1'b1;
      end
   end

   always_comb begin
      lk_busy = '0;
      for (int i = 0; i < NREAD; i++) begin
         lk_busy[i] = r_busy[lk_addr[i]];
      end
   end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-read-port register file with busy scoreboard, x0 = 0 and
//            a trigger-mirror register. Optional macro: REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp #(
   parameter int XLEN     = regfile_pkg::XLEN,
   parameter int NREGS    = regfile_pkg::NREGS,
   parameter int NREAD    = 2,
   parameter int TRIG_IDX = regfile_pkg::TRIG_IDX
) (
   input  wire logic                          clk,
   input  wire logic                          rst_n,
   input  wire logic                          trigger,
   regfile_mp_if.slave                        bus,
   output logic      [NREGS-1:0][XLEN-1:0]    dump
);
   import regfile_pkg::*;

   localparam int AW = $clog2(NREGS);

   logic [NREGS-1:0][XLEN-1:0] r_regs;
   logic [NREAD-1:0][XLEN-1:0] w_rd_data;
   logic [NREAD-1:0]           w_rd_busy;
   logic [NREAD-1:0]           w_sb_busy;
   logic                       w_wr_ok;
   logic                       w_iss_ok;

   assign w_wr_ok  = bus.wb_en     && is_writable(int'(bus.wb_addr), TRIG_IDX);
   assign w_iss_ok = bus.iss_valid && is_writable(int'(bus.iss_rd),  TRIG_IDX);

   regfile_scoreboard #(
      .NREGS    (NREGS),
      .NREAD    (NREAD),
      .TRIG_IDX (TRIG_IDX),
      .AW       (AW)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .iss_valid (bus.iss_valid),
      .iss_rd    (bus.iss_rd),
      .wb_en     (bus.wb_en),
      .wb_addr   (bus.wb_addr),
      .lk_addr   (bus.rd_addr),
      .lk_busy   (w_sb_busy)
   );

   // Entry 0 is never written, so it holds its reset value of zero forever.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_regs <= '0;
      end else begin
         r_regs[TRIG_IDX] <= XLEN'(trigger);
         if (w_wr_ok) r_regs[bus.wb_addr] <= bus.wb_data;
      end
   end

   always_comb begin
      w_rd_data = '0;
      w_rd_busy = '0;
      for (int i = 0; i < NREAD; i++) begin
         if (bus.rd_addr[i] != AW'(REG_ZERO)) begin
            w_rd_data[i] = r_regs[bus.rd_addr[i]];
            w_rd_busy[i] = w_sb_busy[i];
         end
`ifdef REGFILE_BYPASS_EN
         // Forward the in-flight writeback; a same-cycle re-issue keeps stored busy.
         if (w_wr_ok && (bus.wb_addr == bus.rd_addr[i])) begin
            w_rd_data[i] = bus.wb_data;
            if (!(w_iss_ok && (bus.iss_rd == bus.wb_addr))) w_rd_busy[i] = 1'b0;
         end
`endif
      end
   end

`ifndef REGFILE_BYPASS_EN
   logic w_unused;
   assign w_unused = w_iss_ok;
`endif

   assign bus.rd_data = w_rd_data;
   assign bus.rd_busy = w_rd_busy;
   assign dump        = r_regs;

endmodule

`default_nettype wire
